vcortex_lb_seq: RTL and testbench
=================================

# vcortex_lb_seq

Local-bus initiator that drives the VCORTEX local-bus slave port from the sequencing side. When started, it pulls P_NO_CHANNELS duty values from an input stream and writes them to consecutive PWM RAM addresses, optionally reading each one back for verification. It then writes the control register to enable PWM generation and reports completion or error. It sits between the upstream pattern/DSP logic and the VCORTEX local-bus inputs.

## Interface
- P_LB_ADDR_W, 12, local-bus address width
- P_LB_DATA_W, 16, local-bus data width (= duty width)
- P_NO_CHANNELS, 16, duty words per frame
- P_PWM_RAM_BASE, 12'h000, address of channel 0; channel n at base+n
- P_CTRL_ADDR, 12'h100, control register; bit0 = PWM generator enable
- P_TIMEOUT, 255, max wait cycles for a response (8-bit counter)

Ports:
- clk_ir  in  1  clock
- rst_il  in  1  reset; asynchronous, active-low
- start_ih  in  1  start frame load; sampled in IDLE only
- verify_en_ih  in  1  1 -> read back each write; sampled with start
- busy_oh  out  1  1 from accepted start until done pulse
- done_oh  out  1  one-cycle completion pulse
- err_oh  out  1  error status; valid with done, held until next accepted start
- duty_valid_ih  in  1  duty word available
- duty_data_id  in  P_LB_DATA_W  duty word
- duty_ready_oh  out  1  sequencer accepts duty word
- lb_rd_en_oh  out  1  read strobe
- lb_wr_en_oh  out  1  write strobe
- lb_addr_od  out  P_LB_ADDR_W  address
- lb_wr_data_od  out  P_LB_DATA_W  write data
- lb_rd_valid_ih  in  1  read response valid
- lb_wr_valid_ih  in  1  write acknowledge
- lb_rd_data_id  in  P_LB_DATA_W  read data

## Operation
- States: IDLE, FETCH, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, CTRL_ISSUE, CTRL_WAIT, FIN.
- IDLE: on start_ih=1, clear err_oh, latch verify_en_ih, clear channel counter ch, go FETCH.
- FETCH: duty_ready_oh=1; on duty_valid_ih & duty_ready_oh, capture word into data register, go WR_ISSUE.
- WR_ISSUE: lb_wr_en_oh=1 for exactly one cycle, addr=P_PWM_RAM_BASE+ch, data=captured word; go WR_WAIT.
- WR_WAIT: on lb_wr_valid_ih: if verify go RD_ISSUE, else advance.
- RD_ISSUE: lb_rd_en_oh=1 one cycle, same addr; go RD_WAIT.
- RD_WAIT: on lb_rd_valid_ih compare lb_rd_data_id to captured word; mismatch -> err_oh=1, go FIN; match -> advance.
- Advance: if ch==P_NO_CHANNELS-1 go CTRL_ISSUE, else ch+1, go FETCH.
- CTRL_ISSUE: lb_wr_en_oh=1 one cycle, addr=P_CTRL_ADDR, data=16'h0001; go CTRL_WAIT; on ack go FIN.
- FIN: done_oh=1 one cycle, busy_oh drops same edge, go IDLE.
- Timeout: in any *_WAIT state, wait counter increments each cycle; reaching P_TIMEOUT without response -> err_oh=1, go FIN (control register not written).
- Only one transaction outstanding; rd/wr strobes never asserted together.
- Responses arriving outside the matching WAIT state are ignored.
- start_ih while busy: ignored. FETCH stalls indefinitely (no timeout) waiting for duty_valid_ih.

## Timing
- All outputs registered. Reset values: all strobes, busy_oh, done_oh, err_oh, duty_ready_oh = 0; lb_addr_od, lb_wr_data_od = 0; state IDLE; ch = 0.
- busy_oh rises the cycle after start sampled.
- lb_addr_od/lb_wr_data_od stable from ISSUE cycle until response accepted.
- Response accepted in the same cycle it is seen in WAIT; wait counter cleared on every ISSUE.
- Zero-wait slave (response one cycle after strobe): 3 cycles/channel without verify (FETCH, ISSUE, WAIT), 5 with verify; frame = 16*3+2+1 = 51 cycles after start with duty always valid.
- Reset mid-frame: immediately returns to IDLE, strobes deassert asynchronously; no done pulse.

## Test plan
- Frame, verify off, duty words 16'h0000..16'h000F always valid, slave acks next cycle -> 16 writes addr 0..15 with matching data, then write 12'h100 data 16'h0001; done at cycle 51, err=0.
- Verify on, slave returns stored data -> write/read pairs per address, done with err=0; corrupt read of channel 5 (16'hDEAD) -> err=1, done, no ctrl write, 6 writes total.
- Slave never acks channel 3 write -> after 255 wait cycles err=1, done pulse, busy low.
- duty_valid_ih gaps of random 0-10 cycles -> no strobe issued while starved; all 16 values written in order.
- start_ih pulsed while busy and spurious lb_wr_valid_ih in FETCH -> ignored; frame result unchanged.
- rst_il low during channel 7 WR_WAIT -> all outputs 0 immediately; new start restarts at channel 0.

Source files
------------

// File: rtl/vcortex_lb_seq.sv
// vcortex_lb_seq: local-bus initiator that loads one frame of PWM duty words
// into the VCORTEX PWM RAM, optionally verifies each word by read-back, then
// enables the PWM generator through the control register.
module vcortex_lb_seq #(
  parameter int unsigned            P_LB_ADDR_W    = 12,
  parameter int unsigned            P_LB_DATA_W    = 16,
  parameter int unsigned            P_NO_CHANNELS  = 16,
  parameter logic [P_LB_ADDR_W-1:0] P_PWM_RAM_BASE = 12'h000,
  parameter logic [P_LB_ADDR_W-1:0] P_CTRL_ADDR    = 12'h100,
  parameter int unsigned            P_TIMEOUT      = 255
) (
  input  logic                   clk_ir,
  input  logic                   rst_il,
  input  logic                   start_ih,
  input  logic                   verify_en_ih,
  output logic                   busy_oh,
  output logic                   done_oh,
  output logic                   err_oh,
  input  logic                   duty_valid_ih,
  input  logic [P_LB_DATA_W-1:0] duty_data_id,
  output logic                   duty_ready_oh,
  output logic                   lb_rd_en_oh,
  output logic                   lb_wr_en_oh,
  output logic [P_LB_ADDR_W-1:0] lb_addr_od,
  output logic [P_LB_DATA_W-1:0] lb_wr_data_od,
  input  logic                   lb_rd_valid_ih,
  input  logic                   lb_wr_valid_ih,
  input  logic [P_LB_DATA_W-1:0] lb_rd_data_id
);

  localparam int unsigned CH_W   = (P_NO_CHANNELS > 1) ? $clog2(P_NO_CHANNELS) : 1;
  localparam int unsigned WAIT_W = 8;
  localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(P_NO_CHANNELS - 1);
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(P_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE,
    S_RD_WAIT, S_CTRL_ISSUE, S_CTRL_WAIT, S_FIN
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CH_W-1:0]        r_ch;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [P_LB_DATA_W-1:0] r_word;
  logic                   r_verify;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_duty_ready;
  logic                   r_rd_en;
  logic                   r_wr_en;
  logic [P_LB_ADDR_W-1:0] r_addr;
  logic [P_LB_DATA_W-1:0] r_wr_data;

  logic w_start_acc;
  logic w_fetch_acc;
  logic w_advance;
  logic w_ch_inc;
  logic w_ctrl_go;
  logic w_err_set;
  logic w_tmo;

  // Last permitted wait cycle without a response
  assign w_tmo = (r_wait_cnt == TMO_LAST);

  // State register
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_fetch_acc = 1'b0;
    w_advance   = 1'b0;
    w_ch_inc    = 1'b0;
    w_ctrl_go   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_ih) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (duty_valid_ih && r_duty_ready) begin
          w_fetch_acc = 1'b1;
          w_state_nxt = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: w_state_nxt = S_WR_WAIT;
      S_WR_WAIT: begin
        if (lb_wr_valid_ih) begin
          if (r_verify) w_state_nxt = S_RD_ISSUE;
          else          w_advance   = 1'b1;
        end else if (w_tmo) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: begin
        if (lb_rd_valid_ih) begin
          if (lb_rd_data_id != r_word) begin
            w_err_set   = 1'b1;
            w_state_nxt = S_FIN;
          end else begin
            w_advance = 1'b1;
          end
        end else if (w_tmo) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_CTRL_ISSUE: w_state_nxt = S_CTRL_WAIT;
      S_CTRL_WAIT: begin
        if (lb_wr_valid_ih) begin
          w_state_nxt = S_FIN;
        end else if (w_tmo) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Channel done: either move to the next channel or enable the generator
    if (w_advance) begin
      if (r_ch == LAST_CH) begin
        w_ctrl_go   = 1'b1;
        w_state_nxt = S_CTRL_ISSUE;
      end else begin
        w_ch_inc    = 1'b1;
        w_state_nxt = S_FETCH;
      end
    end
  end

  // Response wait counter: cleared on every issue, counts while waiting
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WR_ISSUE || r_state == S_RD_ISSUE || r_state == S_CTRL_ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WR_WAIT || r_state == S_RD_WAIT || r_state == S_CTRL_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Frame context: channel index, verify mode, captured duty word, error flag
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_ch     <= '0;
      r_verify <= 1'b0;
      r_word   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_ch     <= '0;
        r_verify <= verify_en_ih;
        r_err    <= 1'b0;
      end
      if (w_ch_inc)    r_ch   <= r_ch + 1'b1;
      if (w_fetch_acc) r_word <= duty_data_id;
      if (w_err_set)   r_err  <= 1'b1;
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_duty_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_addr       <= '0;
      r_wr_data    <= '0;
    end else begin
      r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
      r_done       <= (w_state_nxt == S_FIN);
      r_duty_ready <= (w_state_nxt == S_FETCH);
      r_wr_en      <= (w_state_nxt == S_WR_ISSUE) || (w_state_nxt == S_CTRL_ISSUE);
      r_rd_en      <= (w_state_nxt == S_RD_ISSUE);
      if (w_fetch_acc) begin
        r_addr    <= P_PWM_RAM_BASE + P_LB_ADDR_W'(r_ch);
        r_wr_data <= duty_data_id;
      end else if (w_ctrl_go) begin
        r_addr    <= P_CTRL_ADDR;
        r_wr_data <= P_LB_DATA_W'(1);
      end
    end
  end

  assign busy_oh       = r_busy;
  assign done_oh       = r_done;
  assign err_oh        = r_err;
  assign duty_ready_oh = r_duty_ready;
  assign lb_wr_en_oh   = r_wr_en;
  assign lb_rd_en_oh   = r_rd_en;
  assign lb_addr_od    = r_addr;
  assign lb_wr_data_od = r_wr_data;

endmodule

// File: tb/tb_vcortex_lb_seq.sv
// Bench for vcortex_lb_seq: random duty source and local-bus slave around the
// DUT, with expected transactions derived from the frame-level rules.
module tb_vcortex_lb_seq;

  localparam int NCH  = 16;
  localparam int BASE = 0;
  localparam logic [11:0] CTRL = 12'h100;

  logic        clk_ir = 1'b0;
  logic        rst_il = 1'b0;
  logic        start_ih = 1'b0;
  logic        verify_en_ih = 1'b0;
  logic        busy_oh, done_oh, err_oh;
  logic        duty_valid_ih = 1'b0;
  logic [15:0] duty_data_id = '0;
  logic        duty_ready_oh;
  logic        lb_rd_en_oh, lb_wr_en_oh;
  logic [11:0] lb_addr_od;
  logic [15:0] lb_wr_data_od;
  logic        lb_rd_valid_ih = 1'b0;
  logic        lb_wr_valid_ih = 1'b0;
  logic [15:0] lb_rd_data_id = '0;

  always #5 clk_ir = ~clk_ir;

  vcortex_lb_seq dut (
    .clk_ir(clk_ir), .rst_il(rst_il), .start_ih(start_ih), .verify_en_ih(verify_en_ih),
    .busy_oh(busy_oh), .done_oh(done_oh), .err_oh(err_oh),
    .duty_valid_ih(duty_valid_ih), .duty_data_id(duty_data_id), .duty_ready_oh(duty_ready_oh),
    .lb_rd_en_oh(lb_rd_en_oh), .lb_wr_en_oh(lb_wr_en_oh), .lb_addr_od(lb_addr_od),
    .lb_wr_data_od(lb_wr_data_od), .lb_rd_valid_ih(lb_rd_valid_ih),
    .lb_wr_valid_ih(lb_wr_valid_ih), .lb_rd_data_id(lb_rd_data_id)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Frame configuration and scoreboard state
  logic [15:0] words [NCH];
  logic [15:0] mem   [NCH];
  logic [15:0] rd_ret;
  int  cyc, src_idx, gap, gmax, dmax, cnt_wr, cnt_rd;
  int  n_cons, n_wr, n_rd, n_ctrl, n_done, t_start, t_done;
  int  noack_ch, corrupt_ch;
  bit  prev_ready, pend_wr, pend_rd, start_req, spur, verify;
  bit  err_at_done, busy_at_done;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rnd(input int mx);
    return (mx == 0) ? 0 : int'($urandom_range(mx, 0));
  endfunction

  // One clock: observe DUT outputs just after the edge, then drive inputs
  task automatic step();
    int ch;
    @(posedge clk_ir);
    #1;
    cyc++;
    // duty source
    if (duty_valid_ih && prev_ready) begin
      n_cons++;
      src_idx++;
      gap = rnd(gmax);
    end
    prev_ready = duty_ready_oh;
    if (src_idx < NCH && gap == 0) begin
      duty_valid_ih = 1'b1;
      duty_data_id  = words[src_idx];
    end else begin
      duty_valid_ih = 1'b0;
      if (gap > 0) gap--;
    end
    // slave responses
    lb_wr_valid_ih = 1'b0;
    lb_rd_valid_ih = 1'b0;
    if (pend_wr) begin
      if (cnt_wr == 0) begin lb_wr_valid_ih = 1'b1; pend_wr = 1'b0; end
      else cnt_wr--;
    end
    if (pend_rd) begin
      if (cnt_rd == 0) begin lb_rd_valid_ih = 1'b1; lb_rd_data_id = rd_ret; pend_rd = 1'b0; end
      else cnt_rd--;
    end
    // bus monitor
    if (lb_wr_en_oh || lb_rd_en_oh) chk("excl", int'(lb_wr_en_oh & lb_rd_en_oh), 0);
    if (lb_wr_en_oh) begin
      if (lb_addr_od == CTRL) begin
        n_ctrl++;
        chk("ctrl_data", int'(lb_wr_data_od), 1);
        pend_wr = 1'b1;
        cnt_wr  = rnd(dmax);
      end else begin
        chk("starve", int'(n_wr < n_cons), 1);
        chk("wr_addr", int'(lb_addr_od), BASE + n_wr);
        chk("wr_data", int'(lb_wr_data_od), (n_wr < NCH) ? int'(words[n_wr]) : -1);
        ch = int'(lb_addr_od) - BASE;
        if (ch >= 0 && ch < NCH) mem[ch] = lb_wr_data_od;
        if (ch != noack_ch) begin
          pend_wr = 1'b1;
          cnt_wr  = rnd(dmax);
        end
        n_wr++;
      end
    end
    if (lb_rd_en_oh) begin
      ch = int'(lb_addr_od) - BASE;
      chk("rd_addr", ch, n_wr - 1);
      if (ch == corrupt_ch)          rd_ret = 16'hDEAD;
      else if (ch >= 0 && ch < NCH)  rd_ret = mem[ch];
      else                           rd_ret = 16'h0;
      pend_rd = 1'b1;
      cnt_rd  = rnd(dmax);
      n_rd++;
    end
    // spurious write ack while fetching, spurious start while busy
    if (spur && !pend_wr && !lb_wr_valid_ih && duty_ready_oh && $urandom_range(1, 0) == 1)
      lb_wr_valid_ih = 1'b1;
    start_ih = start_req || (spur && busy_oh && $urandom_range(3, 0) == 0);
    if (start_req) t_start = cyc;
    start_req = 1'b0;
    if (done_oh) begin
      n_done++;
      t_done       = cyc;
      err_at_done  = err_oh;
      busy_at_done = busy_oh;
    end
  endtask

  task automatic fill_words(input bit seq);
    for (int i = 0; i < NCH; i++) words[i] = seq ? 16'(i) : 16'($urandom);
  endtask

  task automatic arm(input bit vfy, input int corrupt, input int noack,
                     input int gm, input int dm, input bit sp);
    verify = vfy; verify_en_ih = vfy;
    corrupt_ch = corrupt; noack_ch = noack;
    gmax = gm; dmax = dm; spur = sp;
    src_idx = 0; n_cons = 0; n_wr = 0; n_rd = 0; n_ctrl = 0; n_done = 0;
    pend_wr = 1'b0; pend_rd = 1'b0;
    gap = rnd(gm);
    start_req = 1'b1;
  endtask

  // Run one frame and compare its outcome with the frame-level expectation
  task automatic run_frame(input string nm, input bit vfy, input int corrupt, input int noack,
                           input int gm, input int dm, input bit sp, input int exp_cycles);
    int exp_wr, exp_rd, exp_ctrl;
    bit exp_err;
    arm(vfy, corrupt, noack, gm, dm, sp);
    for (int i = 0; i < 4000 && n_done == 0; i++) step();
    if (noack >= 0) begin
      exp_wr = noack + 1; exp_rd = vfy ? noack : 0; exp_ctrl = 0; exp_err = 1'b1;
    end else if (vfy && corrupt >= 0) begin
      exp_wr = corrupt + 1; exp_rd = corrupt + 1; exp_ctrl = 0; exp_err = 1'b1;
    end else begin
      exp_wr = NCH; exp_rd = vfy ? NCH : 0; exp_ctrl = 1; exp_err = 1'b0;
    end
    chk({nm, ":done_seen"}, n_done, 1);
    chk({nm, ":err_at_done"}, int'(err_at_done), int'(exp_err));
    chk({nm, ":busy_at_done"}, int'(busy_at_done), 0);
    if (exp_cycles > 0) chk({nm, ":cycles"}, t_done - t_start, exp_cycles);
    for (int i = 0; i < 5; i++) step();
    chk({nm, ":one_done"}, n_done, 1);
    chk({nm, ":writes"}, n_wr, exp_wr);
    chk({nm, ":reads"}, n_rd, exp_rd);
    chk({nm, ":ctrl_writes"}, n_ctrl, exp_ctrl);
    chk({nm, ":busy_after"}, int'(busy_oh), 0);
    chk({nm, ":err_held"}, int'(err_oh), int'(exp_err));
  endtask

  initial begin
    cyc = 0; noack_ch = -1; corrupt_ch = -1; gmax = 0; dmax = 0; spur = 1'b0;
    src_idx = NCH; gap = 0; prev_ready = 1'b0; pend_wr = 1'b0; pend_rd = 1'b0;
    start_req = 1'b0; n_done = 0;
    fill_words(1'b1);
    for (int i = 0; i < 3; i++) step();
    rst_il = 1'b1;
    step();
    chk("rst_busy", int'(busy_oh), 0);
    chk("rst_done", int'(done_oh), 0);
    chk("rst_err", int'(err_oh), 0);
    chk("rst_strobes", int'({lb_wr_en_oh, lb_rd_en_oh, duty_ready_oh}), 0);
    chk("rst_addr", int'(lb_addr_od), 0);
    chk("rst_wdata", int'(lb_wr_data_od), 0);

    // zero-wait frames: 3 cycles/channel without verify, 5 with, plus ctrl and FIN
    fill_words(1'b1);
    run_frame("base", 1'b0, -1, -1, 0, 0, 1'b0, NCH * 3 + 3);
    run_frame("verify", 1'b1, -1, -1, 0, 0, 1'b0, NCH * 5 + 3);
    run_frame("corrupt5", 1'b1, 5, -1, 0, 0, 1'b0, 0);
    // channel 3 write never acked: 3 full channels, fetch, issue, 255 waits, FIN
    run_frame("timeout3", 1'b0, -1, 3, 0, 0, 1'b0, 3 * 3 + 2 + 255 + 1);
    run_frame("spurious", 1'b0, -1, -1, 0, 0, 1'b1, NCH * 3 + 3);
    fill_words(1'b0);
    run_frame("gaps", 1'($urandom_range(1, 0)), -1, -1, 10, 3, 1'b0, 0);

    // reset while channel 7 waits for its write ack
    fill_words(1'b1);
    arm(1'b0, -1, 7, 0, 0, 1'b0);
    for (int i = 0; i < 500 && n_wr < 8; i++) step();
    chk("rst7:reached", int'(n_wr >= 8), 1);
    step();
    #2 rst_il = 1'b0;
    #1;
    chk("rst7:busy", int'(busy_oh), 0);
    chk("rst7:outs", int'({done_oh, err_oh, lb_wr_en_oh, lb_rd_en_oh, duty_ready_oh}), 0);
    chk("rst7:bus", int'({lb_addr_od, lb_wr_data_od}), 0);
    for (int i = 0; i < 3; i++) step();
    chk("rst7:no_done", n_done, 0);
    rst_il = 1'b1;
    step();
    run_frame("after_rst", 1'b1, -1, -1, 0, 0, 1'b0, NCH * 5 + 3);

    for (int k = 0; k < 3; k++) begin
      fill_words(1'b0);
      run_frame("random", 1'($urandom_range(1, 0)), -1, -1, rnd(6), rnd(3), 1'b1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
